// File: rtl/alu_pipe.sv
// alu_pipe: handshaked, registered ALU sitting between the register-file
// read stage and the C pipeline register.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   in_valid / in_ready        operand handshake (Ain, Bin, ALUop captured on transfer)
//   Ain, Bin [WIDTH-1:0]       operands
//   ALUop [2:0]                000 ADD, 001 SUB, 010 AND, 011 NOT(~Bin), 100 OR,
//                              101 XOR, 110 SHL (Ain << Bin[SHW-1:0]), 111 MUL
//   out_valid / out_ready      result handshake
//   out [WIDTH-1:0], Z, N, V   registered result and flags
//
// Build option: define ALU_MUL_EN to build the iterative shift-add multiplier
// (states IDLE/MUL/HOLD). Without it, ALUop 111 finishes in one cycle with
// out = 0, Z = 1, N = 0, V = 1 as an illegal-op marker.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic [2:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             Z,
    output logic             N,
    output logic             V
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             z_q, z_d, n_q, n_d, v_q, v_d;
    logic             out_valid_q, out_valid_d;

    // Slot can take a new result: empty, or being drained on this edge.
    logic slot_free;
    assign slot_free = !out_valid_q || out_ready;

    // Single-cycle ALU on the live inputs.
    logic [WIDTH-1:0] sum, diff, alu_res;
    logic             alu_v;

    always_comb begin
        sum     = Ain + Bin;
        diff    = Ain - Bin;
        alu_res = '0;
        alu_v   = 1'b0;
        case (ALUop)
            3'b000: begin
                alu_res = sum;
                alu_v   = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (sum[WIDTH-1] != Ain[WIDTH-1]);
            end
            3'b001: begin
                alu_res = diff;
                alu_v   = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (diff[WIDTH-1] != Ain[WIDTH-1]);
            end
            3'b010:  alu_res = Ain & Bin;
            3'b011:  alu_res = ~Bin;
            3'b100:  alu_res = Ain | Bin;
            3'b101:  alu_res = Ain ^ Bin;
            3'b110:  alu_res = Ain << Bin[SHW-1:0];
            default: begin
`ifdef ALU_MUL_EN
                // Handled by the multiplier; never loaded from here.
                alu_res = '0;
                alu_v   = 1'b0;
`else
                alu_res = '0;
                alu_v   = 1'b1;
`endif
            end
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

    state_t             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] acc_step, prod;
    logic               accept;

    assign in_ready = !reset && (state_q == S_IDLE) && slot_free;
    assign accept   = in_valid && in_ready;
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    // In HOLD the finished product sits in acc_q; in MUL it is the final step.
    assign prod     = (state_q == S_HOLD) ? acc_q : acc_step;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        out_d       = out_q;
        v_d         = v_q;
        out_valid_d = out_valid_q && !out_ready;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (ALUop == 3'b111) begin
                        state_d  = S_MUL;
                        mcand_d  = {{WIDTH{1'b0}}, Ain};
                        mplier_d = Bin;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        out_d       = alu_res;
                        v_d         = alu_v;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    if (slot_free) begin
                        out_d       = prod[WIDTH-1:0];
                        v_d         = |prod[2*WIDTH-1:WIDTH];
                        out_valid_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (slot_free) begin
                    out_d       = prod[WIDTH-1:0];
                    v_d         = |prod[2*WIDTH-1:WIDTH];
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        z_d = (out_d == '0);
        n_d = out_d[WIDTH-1];
        // Flags only change when a result loads, so they track out_d.
        if (!out_valid_d || (out_d == out_q && v_d == v_q)) begin
            z_d = (out_d == '0) ? (out_valid_d ? 1'b1 : z_q) : 1'b0;
            n_d = out_d[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end
`else
    logic accept;

    assign in_ready = !reset && slot_free;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_d       = out_q;
        v_d         = v_q;
        z_d         = z_q;
        n_d         = n_q;
        out_valid_d = out_valid_q && !out_ready;
        if (accept) begin
            out_d       = alu_res;
            v_d         = alu_v;
            z_d         = (alu_res == '0);
            n_d         = alu_res[WIDTH-1];
            out_valid_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            z_q         <= z_d;
            n_q         <= n_d;
            v_q         <= v_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign Z         = z_q;
    assign N         = n_q;
    assign V         = v_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [15:0] Ain, Bin;
    logic [2:0]  ALUop;
    logic        out_valid, out_ready;
    logic [15:0] out;
    logic        Z, N, V;

    int n_chk  = 0;
    int n_fail = 0;
    logic last_rdy, last_acc;
    logic [18:0] sbq[$];   // {out, Z, N, V} expected, in acceptance order

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(16)) dut (
        .clk(clk), .reset(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .Ain(Ain), .Bin(Bin), .ALUop(ALUop),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .Z(Z), .N(N), .V(V)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: signed overflow judged by exact integer range, product by plain multiply.
    function automatic logic [18:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int          sa, sb, s;
        int unsigned p;
        logic [15:0] r;
        logic        v;
        sa = $signed(a);
        sb = $signed(b);
        v  = 1'b0;
        r  = '0;
        case (op)
            3'd0: begin s = sa + sb; r = a + b; v = (s > 32767) || (s < -32768); end
            3'd1: begin s = sa - sb; r = a - b; v = (s > 32767) || (s < -32768); end
            3'd2: r = a & b;
            3'd3: r = ~b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = a << (b % 16);
            default: begin
`ifdef ALU_MUL_EN
                p = a * b;
                r = p[15:0];
                v = (p >= 32'd65536);
`else
                p = 0;
                r = '0;
                v = 1'b1;
`endif
            end
        endcase
        return {r, (r == 16'd0), r[15], v};
    endfunction

    // One clock cycle: drive at negedge, sample handshakes, cross the posedge, stop at next negedge.
    task automatic cycle(input logic iv, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic ordy);
        in_valid  = iv;
        ALUop     = op;
        Ain       = a;
        Bin       = b;
        out_ready = ordy;
        #1;
        last_rdy = in_ready;
        last_acc = iv && in_ready;
        if (rst) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) chk("sb_unexpected", {31'd0, out_valid}, 32'd0);
                else chk("sb_result", {13'd0, out, Z, N, V}, {13'd0, sbq.pop_front()});
            end
            if (last_acc) sbq.push_back(model(op, a, b));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; in_valid = 0; Ain = 0; Bin = 0; ALUop = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out", {16'd0, out}, 32'd0);
        chk("rst_flags", {29'd0, Z, N, V}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        cycle(1, 3'd1, 16'h7FFF, 16'hFFFF, 1);
        $display("SUB 7FFF-FFFF -> out=%h Z=%b N=%b V=%b", out, Z, N, V);
        chk("sub_valid", {31'd0, out_valid}, 32'd1);
        chk("sub_out", {16'd0, out}, 32'h8000);
        chk("sub_flags", {29'd0, Z, N, V}, 32'b011);

        cycle(1, 3'd0, 16'h8000, 16'h8000, 1);
        $display("ADD 8000+8000 -> out=%h Z=%b N=%b V=%b", out, Z, N, V);
        chk("add_out", {16'd0, out}, 32'h0000);
        chk("add_flags", {29'd0, Z, N, V}, 32'b101);

        cycle(1, 3'd2, 16'hF0F0, 16'h0FF0, 1);
        $display("AND -> out=%h", out);
        chk("and_acc", {31'd0, last_acc}, 32'd1);
        chk("and_out", {16'd0, out}, 32'h00F0);
        cycle(1, 3'd5, 16'hFFFF, 16'h00FF, 1);
        $display("XOR -> out=%h", out);
        chk("xor_acc", {31'd0, last_acc}, 32'd1);
        chk("xor_out", {16'd0, out}, 32'hFF00);
        cycle(1, 3'd6, 16'h0001, 16'h0013, 1);
        $display("SHL -> out=%h", out);
        chk("shl_acc", {31'd0, last_acc}, 32'd1);
        chk("shl_out", {16'd0, out}, 32'h0008);
        cycle(0, 3'd0, 0, 0, 1);
        chk("drained_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure on a 1-cycle op: result stays put, input blocked.
        cycle(1, 3'd0, 16'd1, 16'd2, 0);
        chk("bp_out", {16'd0, out}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 3'd4, 16'h1111, 16'h2222, 0);
            $display("stall %0d: in_ready=%b out=%h", i, last_rdy, out);
            chk("bp_in_ready", {31'd0, last_rdy}, 32'd0);
            chk("bp_stable", {13'd0, out, Z, N, V}, {13'd0, 16'd3, 3'b000});
        end
        cycle(1, 3'd4, 16'h00F0, 16'h0F00, 1);
        chk("bp_same_edge_acc", {31'd0, last_acc}, 32'd1);
        chk("bp_same_edge_out", {16'd0, out}, 32'h0FF0);
        cycle(0, 3'd0, 0, 0, 1);

`ifdef ALU_MUL_EN
        cycle(1, 3'd7, 16'h0100, 16'h0101, 1);
        chk("mul1_acc", {31'd0, last_acc}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            cycle(0, 3'd0, 0, 0, 1);
            chk("mul1_busy", {31'd0, last_rdy}, 32'd0);
            if (i < 15) chk("mul1_not_done", {31'd0, out_valid}, 32'd0);
        end
        $display("MUL 0100*0101 -> out=%h V=%b", out, V);
        chk("mul1_valid", {31'd0, out_valid}, 32'd1);
        chk("mul1_out", {13'd0, out, Z, N, V}, {13'd0, 16'h0100, 3'b001});

        cycle(1, 3'd7, 16'd3, 16'd5, 1);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            cycle(0, 3'd0, 0, 0, 1);
            cyc++;
        end
        $display("MUL 3*5 -> out=%h V=%b after %0d cycles", out, V, cyc);
        chk("mul2_latency", cyc, 32'd16);
        chk("mul2_out", {13'd0, out, Z, N, V}, {13'd0, 16'd15, 3'b000});
        cycle(0, 3'd0, 0, 0, 1);

        // MUL finishing under backpressure, then drain with same-edge reload.
        cycle(1, 3'd7, 16'd7, 16'd9, 0);
        repeat (16) cycle(0, 3'd0, 0, 0, 0);
        chk("mul_bp_out", {16'd0, out}, 32'd63);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 3'd0, 16'd4, 16'd4, 0);
            chk("mul_bp_in_ready", {31'd0, last_rdy}, 32'd0);
            chk("mul_bp_stable", {15'd0, out, out_valid}, {15'd0, 16'd63, 1'b1});
        end
        cycle(1, 3'd0, 16'd4, 16'd4, 1);
        chk("mul_bp_reload", {16'd0, out}, 32'd8);
        cycle(0, 3'd0, 0, 0, 1);

        // Reset mid-multiply.
        cycle(1, 3'd7, 16'h1234, 16'h5678, 1);
        repeat (4) cycle(0, 3'd0, 0, 0, 1);
        rst = 1'b1;
        cycle(0, 3'd0, 0, 0, 1);
        chk("rst_mid_in_ready", {31'd0, last_rdy}, 32'd0);
        rst = 1'b0;
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        cycle(1, 3'd0, 16'd2, 16'd3, 1);
        $display("ADD 2+3 after reset -> out=%h", out);
        chk("rst_mid_acc", {31'd0, last_acc}, 32'd1);
        chk("rst_mid_add", {15'd0, out, out_valid}, {15'd0, 16'd5, 1'b1});
        cycle(0, 3'd0, 0, 0, 1);
`else
        cycle(1, 3'd7, 16'h1234, 16'h5678, 1);
        $display("op 111 (no MUL) -> out=%h Z=%b N=%b V=%b", out, Z, N, V);
        chk("illegal_op", {12'd0, out, out_valid, Z, N, V}, {12'd0, 16'd0, 4'b1101});
        cycle(1, 3'd0, 16'd2, 16'd3, 1);
        rst = 1'b1;
        cycle(0, 3'd0, 0, 0, 0);
        rst = 1'b0;
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        cycle(1, 3'd0, 16'd2, 16'd3, 1);
        chk("rst_add", {15'd0, out, out_valid}, {15'd0, 16'd5, 1'b1});
        cycle(0, 3'd0, 0, 0, 1);
`endif

        // Random traffic against the scoreboard.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
                  16'($urandom), $urandom_range(0, 3) != 0);
            if (last_acc) $display("rand %0d: op=%0d A=%h B=%h accepted", i, ALUop, Ain, Bin);
        end
        cyc = 0;
        while ((sbq.size() != 0 || out_valid) && cyc < 100) begin
            cycle(0, 3'd0, 0, 0, 1);
            cyc++;
        end
        chk("final_queue_empty", sbq.size(), 32'd0);
        chk("final_out_valid", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
